// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared types and source selection for the common data bus arbiter.
// Supplies the machine-wide defines (`XLEN, `ROB_SIZE_WIDTH, `CDB_SRC_ALU, `CDB_SRC_LSB)
// when global_params.v has not already provided them.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef CDB_SRC_ALU
`define CDB_SRC_ALU 0
`endif
`ifndef CDB_SRC_LSB
`define CDB_SRC_LSB 1
`endif

package cdb_arbiter_pkg;

  typedef enum logic {
    SRC_ALU = 1'(`CDB_SRC_ALU),
    SRC_LSB = 1'(`CDB_SRC_LSB)
  } cdb_src_e;

  // One queued result: destination ROB entry plus its value.
  typedef struct packed {
    logic [`ROB_SIZE_WIDTH-1:0] rob_id;
    logic [`XLEN-1:0]           val;
  } cdb_entry_t;

  // Chooses which source is granted, given which queues hold data.
  // Only meaningful when at least one queue is non-empty.
  function automatic cdb_src_e pick_src(input logic alu_ne, input logic lsb_ne,
                                        input cdb_src_e last);
`ifdef CDB_LSB_PRIO_EN
    return lsb_ne ? SRC_LSB : SRC_ALU;
`else
    if (alu_ne && lsb_ne) begin
      // Contest: the source that did not win last time goes next.
      return (last == SRC_ALU) ? SRC_LSB : SRC_ALU;
    end
    return lsb_ne ? SRC_LSB : SRC_ALU;
`endif
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: per-source result queue, DEPTH entries of cdb_entry_t.
// Ports: clk/rst (sync, active-high), en (global enable, low freezes), flush (empties),
// push/push_dat (enqueue, dropped when full), pop (dequeue head), head_dat, full, empty.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       flush,
  input  logic       push,
  input  cdb_entry_t push_dat,
  input  logic       pop,
  output cdb_entry_t head_dat,
  output logic       full,
  output logic       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  // Storage is never reset; only the pointers/count define what is valid.
  cdb_entry_t    mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  // Full is taken from the registered count, so a same-cycle pop never makes room.
  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign head_dat = mem[rd_ptr_q];

  always_comb begin
    push_ok  = 1'b0;
    pop_ok   = 1'b0;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (en) begin
      if (flush) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        cnt_d    = '0;
      end else begin
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: merges ALU and LSB results onto the common data bus, one per cycle.
// Ports: clk, rst (sync, active-high), rdy (low freezes), flush; alu_*/lsb_* result inputs
// with *_full backpressure; cdb_ready/cdb_rob_id/cdb_val registered broadcast.
// Macro CDB_LSB_PRIO_EN: LSB wins every contest instead of round-robin.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       alu_ready,
  input  logic [`ROB_SIZE_WIDTH-1:0] alu_rob_id,
  input  logic [`XLEN-1:0]           alu_val,
  input  logic                       lsb_ready,
  input  logic [`ROB_SIZE_WIDTH-1:0] lsb_rob_id,
  input  logic [`XLEN-1:0]           lsb_val,
  output logic                       alu_full,
  output logic                       lsb_full,
  output logic                       cdb_ready,
  output logic [`ROB_SIZE_WIDTH-1:0] cdb_rob_id,
  output logic [`XLEN-1:0]           cdb_val
);

  cdb_entry_t alu_head, lsb_head;
  logic       alu_empty, lsb_empty;
  logic       alu_pop, lsb_pop;
  logic       grant_vld;
  cdb_src_e   grant_src;

  cdb_src_e                   last_grant_q, last_grant_d;
  logic                       cdb_ready_q, cdb_ready_d;
  logic [`ROB_SIZE_WIDTH-1:0] cdb_rob_id_q, cdb_rob_id_d;
  logic [`XLEN-1:0]           cdb_val_q, cdb_val_d;

  cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk      (clk),
    .rst      (rst),
    .en       (rdy),
    .flush    (flush),
    .push     (alu_ready),
    .push_dat ({alu_rob_id, alu_val}),
    .pop      (alu_pop),
    .head_dat (alu_head),
    .full     (alu_full),
    .empty    (alu_empty)
  );

  cdb_fifo #(.DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk      (clk),
    .rst      (rst),
    .en       (rdy),
    .flush    (flush),
    .push     (lsb_ready),
    .push_dat ({lsb_rob_id, lsb_val}),
    .pop      (lsb_pop),
    .head_dat (lsb_head),
    .full     (lsb_full),
    .empty    (lsb_empty)
  );

  always_comb begin
    grant_vld = !alu_empty || !lsb_empty;
    grant_src = pick_src(!alu_empty, !lsb_empty, last_grant_q);
    // The queues themselves ignore pop while frozen or flushing.
    alu_pop   = grant_vld && (grant_src == SRC_ALU);
    lsb_pop   = grant_vld && (grant_src == SRC_LSB);

    last_grant_d = last_grant_q;
    cdb_ready_d  = cdb_ready_q;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_val_d    = cdb_val_q;
    if (rdy) begin
      if (flush) begin
        cdb_ready_d  = 1'b0;
        last_grant_d = SRC_LSB;
      end else begin
        cdb_ready_d = grant_vld;
        if (grant_vld) begin
          last_grant_d = grant_src;
          if (grant_src == SRC_ALU) begin
            cdb_rob_id_d = alu_head.rob_id;
            cdb_val_d    = alu_head.val;
          end else begin
            cdb_rob_id_d = lsb_head.rob_id;
            cdb_val_d    = lsb_head.val;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= SRC_LSB;
      cdb_ready_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_val_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      cdb_ready_q  <= cdb_ready_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_val_q    <= cdb_val_d;
    end
  end

  assign cdb_ready  = cdb_ready_q;
  assign cdb_rob_id = cdb_rob_id_q;
  assign cdb_val    = cdb_val_q;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, per-source queue depth; power of two, >=2.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rdy  input  1  global enable; low = freeze all state.
REQ-005 SHALL have port flush  input  1  mispredict flush from ROB.
REQ-006 SHALL have ports alu_ready / lsb_ready  input  1  source result valid.
REQ-007 SHALL have ports alu_rob_id / lsb_rob_id  input  `ROB_SIZE_WIDTH  destination ROB entry.
REQ-008 SHALL have ports alu_val / lsb_val  input  `XLEN  result value.
REQ-009 SHALL have ports alu_full / lsb_full  output  1  source queue full; producer must not push.
REQ-010 SHALL have port cdb_ready  output  1  broadcast valid, exactly one cycle per result.
REQ-011 SHALL have port cdb_rob_id  output  `ROB_SIZE_WIDTH  broadcast ROB entry.
REQ-012 SHALL have port cdb_val  output  `XLEN  broadcast value.

Function
REQ-013 SHALL enqueue {rob_id, val} into a source's queue on posedge when rdy, its ready is high, queue not full, and no rst/flush.
REQ-014 SHALL drop a push attempted while full; other state is unaffected.
REQ-015 SHALL drive x_full combinationally as count==FIFO_DEPTH; a same-cycle pop does not free a slot for that cycle's push.
REQ-016 SHALL grant at most one non-empty queue per cycle, pop its head, and register it onto cdb_* the next cycle.
REQ-017 SHALL give a 2-cycle minimum latency: push at edge t, pop at edge t+1, cdb_ready high in the cycle after edge t+1.
REQ-018 SHALL deassert cdb_ready in any cycle following no grant; cdb_rob_id/cdb_val hold their last value then.
REQ-019 SHALL grant the only non-empty queue when just one is non-empty.
REQ-020 SHALL grant, when both queues are non-empty, the source not recorded in last_grant.
REQ-021 SHALL update last_grant on every grant.
REQ-022 SHALL wrap queue pointers modulo FIFO_DEPTH; count SHALL be $clog2(FIFO_DEPTH)+1 bits.
REQ-023 SHALL preserve per-source FIFO order; no inter-source order is guaranteed.
REQ-024 SHALL, on flush, empty both queues, clear cdb_ready next cycle, reset last_grant, and drop same-cycle pushes.
REQ-025 SHALL, when rdy is low and rst is low, hold every register; inputs are ignored.

Reset
REQ-026 SHALL apply rst regardless of rdy, with priority rst > flush > normal operation.
REQ-027 SHALL reset to: queues empty, pointers 0, cdb_ready=0, cdb_rob_id=0, cdb_val=0, last_grant=LSB, x_full=0.
REQ-028 SHALL leave the queue data arrays uninitialised; this is not observable.

Configuration
REQ-029 SHALL support macro CDB_LSB_PRIO_EN: when defined, LSB wins every contest and last_grant is unused.
REQ-030 SHALL, without CDB_LSB_PRIO_EN, use round-robin per REQ-020/021.

Structure
REQ-031 SHALL take `XLEN and `ROB_SIZE_WIDTH from global_params.v and add the source-ID constants `CDB_SRC_ALU=0 and `CDB_SRC_LSB=1 there.
REQ-032 SHALL implement the queue as one sub-module, cdb_fifo, instantiated twice with identical parameters.

Verification
REQ-033 SHALL verify single ALU push: ALU(id=3,val=0x11) at cycle 0 -> cdb_ready=1, id=3, val=0x11 in cycle 2 only.
REQ-034 SHALL verify round-robin: ALU(1,0xA) and LSB(2,0xB) pushed at cycle 0 -> id 1 in cycle 2, then id 2 in cycle 3; with CDB_LSB_PRIO_EN, order is 2 then 1.
REQ-035 SHALL verify full and drop: three ALU pushes on consecutive cycles with the queue blocked by continuous LSB traffic under CDB_LSB_PRIO_EN -> alu_full=1 after 2 entries; third is lost; ALU ids 5,6 are broadcast later in order.
REQ-036 SHALL verify flush: 2 entries queued, flush=1 with a same-cycle ALU push -> no cdb_ready in the following 3 cycles; full flags 0.
REQ-037 SHALL verify rdy freeze: entry queued, rdy=0 for 4 cycles -> state and outputs unchanged; broadcast occurs 1 cycle after rdy returns.
REQ-038 SHALL verify reset mid-operation: rst with both queues full and rdy=0 -> next cycle all outputs 0, last_grant=LSB, and the next contest is won by ALU.
